// File: rtl/ptw_pkg.sv
// Shared PTW definitions: PTE/VA widths, PTE flag positions, PPN field
// and the memory responder FSM state encoding.
package ptw_pkg;

  localparam int PTE_W = 32;
  localparam int VA_W  = 32;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W_BIT = 2;
  localparam int PTE_X = 3;

  localparam int PPN_LSB = 10;
  localparam int PPN_MSB = 31;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_e;

  function automatic logic pte_is_leaf(
    input logic [PTE_W-1:0] pte
  );
    return pte[PTE_R] | pte[PTE_X];
  endfunction

endpackage

// File: rtl/ptw_mem_array.sv
// Page-table word storage: DEPTH x 32 bits, one synchronous write port
// and one combinational read port (a same-edge write is not seen by the read).
import ptw_pkg::*;

module ptw_mem_array #(
  parameter int DEPTH = 1024,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_idx_i,
  input  logic [PTE_W-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_idx_i,
  output logic [PTE_W-1:0] rd_data_o
);

  logic [PTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/ptw_mem_responder.sv
// PTW memory responder: one read at a time, LATENCY cycles accept->valid,
// preload write port; optional mem_err_o when PTW_MEM_ERR_EN is defined.
import ptw_pkg::*;

module ptw_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_req_valid_i,
  output logic             mem_req_ready_o,
  input  logic [VA_W-1:0]  mem_addr_i,
  output logic             mem_resp_valid_o,
  input  logic             mem_resp_ready_i,
  output logic [PTE_W-1:0] mem_data_o,
`ifdef PTW_MEM_ERR_EN
  output logic             mem_err_o,
`endif
  input  logic             wr_en_i,
  input  logic [VA_W-1:0]  wr_addr_i,
  input  logic [PTE_W-1:0] wr_data_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = VA_W - 2;
  localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  rsp_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [PTE_W-1:0] data_q, data_d;

  logic [IW-1:0]    wr_idx;
  logic             wr_ok;
  logic             rd_ok;
  logic [PTE_W-1:0] rd_data;

  assign wr_idx = wr_addr_i[VA_W-1:2];
  assign wr_ok  = wr_idx < DEPTH_I;
  assign rd_ok  = idx_q < DEPTH_I;

  ptw_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk      (clk),
    .wr_en_i  (wr_en_i & wr_ok),
    .wr_idx_i (wr_idx[AW-1:0]),
    .wr_data_i(wr_data_i),
    .rd_idx_i (idx_q[AW-1:0]),
    .rd_data_o(rd_data)
  );

`ifdef PTW_MEM_ERR_EN
  logic mis_q, mis_d;
  logic err_q, err_d;
`endif

  // Byte-offset bits never select data.
  logic unused_lsb;
  assign unused_lsb = ^{mem_addr_i[1:0], wr_addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    valid_d = valid_q;
    data_d  = data_q;
`ifdef PTW_MEM_ERR_EN
    mis_d   = mis_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      RSP_IDLE: begin
        if (mem_req_valid_i && ready_q) begin
          idx_d   = mem_addr_i[VA_W-1:2];
          cnt_d   = CNT_INIT;
          ready_d = 1'b0;
          state_d = RSP_WAIT;
`ifdef PTW_MEM_ERR_EN
          mis_d   = |mem_addr_i[1:0];
`endif
        end
      end
      RSP_WAIT: begin
        if (cnt_q == 4'd0) begin
          data_d  = rd_ok ? rd_data : '0;
          valid_d = 1'b1;
          state_d = RSP_RESP;
`ifdef PTW_MEM_ERR_EN
          err_d   = ~rd_ok | mis_q;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RSP_RESP: begin
        if (mem_resp_ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = RSP_IDLE;
`ifdef PTW_MEM_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = RSP_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef PTW_MEM_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end

  assign mem_err_o = err_q;
`endif

  assign mem_req_ready_o  = ready_q;
  assign mem_resp_valid_o = valid_q;
  assign mem_data_o       = data_q;

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Randomized self-checking bench: three responders (LATENCY 2, 1, 4)
// sharing one preload port, checked against a word-array reference model.
`timescale 1ns/1ps
module tb_ptw_mem_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0]       resp_valid;
  logic [2:0]       resp_ready;
  logic [2:0]       resp_err;
  logic [2:0][31:0] req_addr;
  logic [2:0][31:0] resp_data;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt [3];

  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ptw_mem_responder #(
      .DEPTH  (DEPTH),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_req_valid_i (req_valid[g]),
      .mem_req_ready_o (req_ready[g]),
      .mem_addr_i      (req_addr[g]),
      .mem_resp_valid_o(resp_valid[g]),
      .mem_resp_ready_i(resp_ready[g]),
      .mem_data_o      (resp_data[g]),
`ifdef PTW_MEM_ERR_EN
      .mem_err_o       (resp_err[g]),
`endif
      .wr_en_i         (wr_en),
      .wr_addr_i       (wr_addr),
      .wr_data_i       (wr_data)
    );
`ifndef PTW_MEM_ERR_EN
    assign resp_err[g] = 1'b0;
`endif
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && resp_valid[k] && resp_ready[k]) hs_cnt[k] <= hs_cnt[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] a);
    if (a[31:2] >= 30'(DEPTH)) return 32'h0;
    return model[a[11:2]];
  endfunction

  function automatic logic ref_err(input logic [31:0] a);
    return (a[31:2] >= 30'(DEPTH)) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'h1000 + ($urandom & 32'h0FFF_FFFC);
    if (sel == 1) return ($urandom_range(0, 1023) << 2) | $urandom_range(1, 3);
    if (sel == 2) return 32'h0000_0FFC;
    return $urandom_range(0, 1023) << 2;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (a[31:2] < 30'(DEPTH)) model[a[11:2]] = d;
  endtask

  task automatic do_read(input int k, input logic [31:0] a, input int hold,
                         output logic [31:0] got);
    int lat;
    int w;
    w = 0;
    while (!req_ready[k] && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("req_ready_wait", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_addr[k] = a;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    chk("ready_drop", 32'(req_ready[k]), 32'd0);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid[k]) lat = i;
    end
    chk("latency", 32'(lat), 32'(lat_of(k)));
    got = resp_data[k];
    chk("data", got, ref_data(a));
`ifdef PTW_MEM_ERR_EN
    chk("err", 32'(resp_err[k]), 32'(ref_err(a)));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(resp_valid[k]), 32'd1);
      chk("hold_data", resp_data[k], got);
      chk("hold_ready", 32'(req_ready[k]), 32'd0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
    chk("resp_drop", 32'(resp_valid[k]), 32'd0);
    chk("ready_back", 32'(req_ready[k]), 32'd1);
  endtask

  task automatic walk(input int k, input logic [31:0] va);
    logic [31:0] a1, a2, e1, p1, p2;
    a1 = 32'h400 + {20'h0, va[31:22], 2'b00};
    e1 = ref_data(a1);
    a2 = {e1[31:10], 10'h0} + {20'h0, va[21:12], 2'b00};
    do_read(k, a1, 0, p1);
    chk("walk_l1", p1, 32'h0000_0801);
    do_read(k, a2, 0, p2);
    chk("walk_leaf", p2, 32'h1100_000F);
  endtask

  task automatic stream(input int k, input int n);
    logic [31:0] q [$];
    int got_n;
    int base;
    got_n = 0;
    base = hs_cnt[k];
    fork
      begin
        for (int i = 0; i < n; i++) begin
          logic [31:0] a;
          bit acc;
          int w;
          a = rand_addr();
          req_valid[k] = 1'b1;
          req_addr[k] = a;
          acc = 1'b0;
          w = 0;
          while (!acc && w < 100) begin
            @(negedge clk);
            acc = req_ready[k];
            if (acc) q.push_back(a);
            @(posedge clk);
            #1;
            w++;
          end
          req_valid[k] = 1'b0;
          if (!acc) chk("stream_accept_timeout", 32'd0, 32'd1);
          repeat ($urandom_range(0, 1)) @(posedge clk);
          #1;
        end
      end
      begin
        int w;
        logic [31:0] ea;
        w = 0;
        while (got_n < n && w < n * 40) begin
          resp_ready[k] = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (resp_valid[k] && resp_ready[k]) begin
            if (q.size() == 0) begin
              chk("stream_spurious", 32'd1, 32'd0);
            end else begin
              ea = q.pop_front();
              chk("stream_data", resp_data[k], ref_data(ea));
`ifdef PTW_MEM_ERR_EN
              chk("stream_err", 32'(resp_err[k]), 32'(ref_err(ea)));
`endif
            end
            got_n++;
          end
          @(posedge clk);
          #1;
          w++;
        end
        resp_ready[k] = 1'b0;
        if (got_n < n) chk("stream_timeout", 32'(got_n), 32'(n));
      end
    join
    resp_ready[k] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
    chk("stream_hs_count", 32'(hs_cnt[k] - base), 32'(n));
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] old;
    int lat;
    bit seen;

    req_valid = '0;
    resp_ready = '0;
    req_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_data", resp_data[k], 32'd0);
      chk("rst_err", 32'(resp_err[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom);
    wr(32'h400, 32'h0000_0801);
    wr(32'h800, 32'h1000_000F);
    wr(32'h804, 32'h1100_000F);
    wr(32'h1000, 32'hBAD0_BAD0);
    wr(32'h0010_0000, 32'hBAD1_BAD1);

    for (int k = 0; k < 3; k++) begin
      do_read(k, 32'h400, 0, got);
      do_read(k, 32'h800, 0, got);
    end

    do_read(0, 32'h800, 5, got);

    for (int k = 0; k < 3; k++) begin
      do_read(k, 32'h1000, 0, got);
      do_read(k, 32'h402, 0, got);
      do_read(k, 32'h0, 0, got);
      do_read(k, 32'hFFC, 1, got);
    end

    old = model[32'h404 >> 2];
    req_valid[0] = 1'b1;
    req_addr[0] = 32'h404;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    wr_addr = 32'h404;
    wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[32'h404 >> 2] = 32'hDEAD_BEEF;
    chk("rbw_valid", 32'(resp_valid[0]), 32'd1);
    chk("rbw_old", resp_data[0], old);
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[0] = 1'b0;
    do_read(0, 32'h404, 0, got);
    chk("rbw_new", got, 32'hDEAD_BEEF);

    req_valid[2] = 1'b1;
    req_addr[2] = 32'h408;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    wr(32'h408, 32'hCAFE_F00D);
    lat = 0;
    for (int i = 0; i < 20 && lat == 0; i++) begin
      if (resp_valid[2]) lat = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("wait_wr_valid", 32'(lat), 32'd1);
    chk("wait_wr_data", resp_data[2], 32'hCAFE_F00D);
    resp_ready[2] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[2] = 1'b0;

    req_valid[2] = 1'b1;
    req_addr[2] = 32'h400;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready[2]), 32'd1);
    chk("mid_rst_valid", 32'(resp_valid[2]), 32'd0);
    chk("mid_rst_data", resp_data[2], 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    resp_ready[2] = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (resp_valid[2]) seen = 1'b1;
    end
    resp_ready[2] = 1'b0;
    chk("mid_rst_no_resp", 32'(seen), 32'd0);
    chk("mid_rst_ready_after", 32'(req_ready[2]), 32'd1);

    for (int k = 0; k < 3; k++) begin
      walk(k, 32'h0000_1000);
      walk(k, 32'h0000_1000);
    end

    for (int k = 0; k < 3; k++) stream(k, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
